// File: rtl/time_ctrl_pkg.sv
// rtl/time_ctrl_pkg.sv - shared constants and types for the time_ctrl button front-end
package time_ctrl_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_SEC  = 2'b01;
    localparam logic [1:0] MODE_MIN  = 2'b10;
    localparam logic [1:0] MODE_HOUR = 2'b11;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Mode cycles 00 -> 01 -> 10 -> 11 -> 00; the 2-bit wrap does the work.
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return m + 2'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, debouncer and press-edge detector for one button
//
// Ports:
//   clk     system clock, rising edge
//   reset_n asynchronous active-low reset
//   btn     raw asynchronous button level, active-high
//   level   debounced stable level
//   press   one-cycle pulse on a rising edge of level
module btn_debounce
    import time_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            level_q <= level;
            // Any return to the stable level restarts the stability window.
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Derived from registers only; the top registers everything it produces from it.
    assign press = level & ~level_q;

endmodule

// File: rtl/time_ctrl.sv
// rtl/time_ctrl.sv - button front-end: debounced mode/run/plus/minus control for the timekeeper
//
// Optional feature macro: TIME_CTRL_AUTO_REPEAT_EN (held plus/minus auto-repeat).
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   btn_mode   raw button, advances mode
//   btn_run    raw button, toggles enable
//   btn_plus   raw button, increment
//   btn_minus  raw button, decrement
//   mode       00 run, 01 set seconds, 10 set minutes, 11 set hours
//   enable     timekeeper run level
//   plus       one-cycle increment pulse
//   minus      one-cycle decrement pulse
module time_ctrl
    import time_ctrl_pkg::*;
#(
    parameter int DEBOUNCE      = 1_000_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_run,
    input  logic       btn_plus,
    input  logic       btn_minus,
    output logic [1:0] mode,
    output logic       enable,
    output logic       plus,
    output logic       minus
);

    logic [3:0] btn_raw;
    logic [3:0] lvl;
    logic [3:0] prs;

    assign btn_raw = {btn_minus, btn_plus, btn_run, btn_mode};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .btn     (btn_raw[i]),
            .level   (lvl[i]),
            .press   (prs[i])
        );
    end

    logic mode_press;
    logic run_press;
    logic plus_lvl;
    logic minus_lvl;
    logic plus_ok;
    logic minus_ok;
    logic plus_n;
    logic minus_n;

    assign mode_press = prs[0];
    assign run_press  = prs[1];
    assign plus_lvl   = lvl[2];
    assign minus_lvl  = lvl[3];

    // A press only counts when the opposite key is not already down; this also
    // drops a simultaneous plus+minus press, since both levels are high then.
    assign plus_ok  = prs[2] & ~minus_lvl & (mode != MODE_RUN);
    assign minus_ok = prs[3] & ~plus_lvl  & (mode != MODE_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode   <= MODE_RUN;
            enable <= 1'b1;
            plus   <= 1'b0;
            minus  <= 1'b0;
        end else begin
            if (mode_press) mode <= next_mode(mode);
            if (run_press)  enable <= ~enable;
            plus  <= plus_n;
            minus <= minus_n;
        end
    end

`ifdef TIME_CTRL_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    rpt_state_t       state, state_n;
    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_n;
    logic             dir_minus, dir_minus_n;
    logic             held_lvl;
    logic             opp_lvl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RPT_IDLE;
            rpt_cnt   <= '0;
            dir_minus <= 1'b0;
        end else begin
            state     <= state_n;
            rpt_cnt   <= rpt_cnt_n;
            dir_minus <= dir_minus_n;
        end
    end

    always_comb begin
        state_n     = state;
        rpt_cnt_n   = rpt_cnt;
        dir_minus_n = dir_minus;
        plus_n      = 1'b0;
        minus_n     = 1'b0;
        held_lvl    = dir_minus ? minus_lvl : plus_lvl;
        opp_lvl     = dir_minus ? plus_lvl  : minus_lvl;
        case (state)
            RPT_IDLE: begin
                if (plus_ok || minus_ok) begin
                    plus_n      = plus_ok;
                    minus_n     = minus_ok;
                    dir_minus_n = minus_ok;
                    rpt_cnt_n   = RPT_W'(REPEAT_DELAY - 1);
                    state_n     = RPT_HOLD;
                end
            end
            RPT_HOLD, RPT_REPEAT: begin
                // Cancellation wins over a repeat pulse due in the same cycle.
                if (!held_lvl || mode_press || opp_lvl) begin
                    rpt_cnt_n = '0;
                    state_n   = RPT_IDLE;
                end else if (rpt_cnt == '0) begin
                    plus_n    = ~dir_minus;
                    minus_n   = dir_minus;
                    rpt_cnt_n = RPT_W'(REPEAT_PERIOD - 1);
                    state_n   = RPT_REPEAT;
                end else begin
                    rpt_cnt_n = rpt_cnt - 1'b1;
                end
            end
            default: begin
                rpt_cnt_n = '0;
                state_n   = RPT_IDLE;
            end
        endcase
    end
`else
    always_comb begin
        plus_n  = plus_ok;
        minus_n = minus_ok;
    end
`endif

endmodule

// File: tb/tb_time_ctrl.sv
// tb/tb_time_ctrl.sv - self-checking bench for time_ctrl (vector table plus multi-cycle sequences)
module tb_time_ctrl;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_plus = 1'b0;
    logic       btn_minus = 1'b0;
    logic [1:0] mode;
    logic       enable;
    logic       plus;
    logic       minus;

    always #5 clk = ~clk;

    time_ctrl #(
        .DEBOUNCE      (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_mode  (btn_mode),
        .btn_run   (btn_run),
        .btn_plus  (btn_plus),
        .btn_minus (btn_minus),
        .mode      (mode),
        .enable    (enable),
        .plus      (plus),
        .minus     (minus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int plus_cnt = 0;
    int minus_cnt = 0;
    int plus_t[$];
    int minus_t[$];

    typedef struct {
        int btn;
        int hold;
        int exp_mode;
        int exp_en;
        int exp_dp;
        int exp_dm;
    } vec_t;

    vec_t vecs[$];

    always @(negedge clk) begin
        cyc++;
        if (plus) begin
            plus_cnt++;
            plus_t.push_back(cyc);
        end
        if (minus) begin
            minus_cnt++;
            minus_t.push_back(cyc);
        end
        if (reset_n && (plus || minus)) begin
            n_checks++;
            if (plus && minus) begin
                n_fail++;
                $display("FAIL plus_minus_overlap: cycle %0d plus=%0b minus=%0b required not both 1", cyc, plus, minus);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: btn_mode  = v;
            1: btn_run   = v;
            2: btn_plus  = v;
            default: btn_minus = v;
        endcase
    endtask

    task automatic hold_btn(input int idx, input int n);
        @(negedge clk);
        set_btn(idx, 1'b1);
        repeat (n) @(negedge clk);
        set_btn(idx, 1'b0);
        repeat (DB + 8) @(negedge clk);
    endtask

    function automatic vec_t mk(input int b, input int h, input int m, input int e, input int dp, input int dm);
        vec_t v;
        v.btn = b; v.hold = h; v.exp_mode = m; v.exp_en = e; v.exp_dp = dp; v.exp_dm = dm;
        return v;
    endfunction

    // Pulses produced by a key held h raw cycles: first at DB+2, repeats at
    // DB+2+RD+k*RP for as long as the debounced level is still high.
    function automatic int rpt_pulses(input int h);
        int n;
        n = 1;
`ifdef TIME_CTRL_AUTO_REPEAT_EN
        for (int t = DB + 2 + RD; t <= h + DB + 1; t += RP) n++;
`endif
        return n;
    endfunction

    initial begin
        int p0, m0;
        int exp_off[$];

        vecs.push_back(mk(1, 6, 0, 1, 0, 0));
        vecs.push_back(mk(0, 6, 1, 1, 0, 0));
        vecs.push_back(mk(0, 6, 2, 1, 0, 0));
        vecs.push_back(mk(0, 6, 3, 1, 0, 0));
        vecs.push_back(mk(0, 6, 0, 1, 0, 0));
        vecs.push_back(mk(0, 6, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 6, 2, 1, 0, 0));
        vecs.push_back(mk(0, 6, 3, 1, 0, 0));
        vecs.push_back(mk(0, 6, 0, 1, 0, 0));
        vecs.push_back(mk(2, 40, 0, 1, 0, 0));
        vecs.push_back(mk(3, 6, 0, 1, 0, 0));
        vecs.push_back(mk(0, 6, 1, 1, 0, 0));
        vecs.push_back(mk(0, 6, 2, 1, 0, 0));
        vecs.push_back(mk(2, 6, 2, 1, 1, 0));
        vecs.push_back(mk(3, 6, 2, 1, 0, 1));
        vecs.push_back(mk(1, 6, 2, 0, 0, 0));
        vecs.push_back(mk(1, 6, 2, 1, 0, 0));

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_enable", enable, 1);
        check("rst_plus", plus, 0);
        check("rst_minus", minus, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_mode", mode, 0);
        check("idle_enable", enable, 1);

        // Run press latency: output changes after edge DB+2 from first sampling edge
        @(negedge clk);
        btn_run = 1'b1;
        repeat (DB + 2) @(posedge clk);
        #1 check("run_lat_before", enable, 1);
        @(posedge clk);
        #1 check("run_lat_after", enable, 0);
        repeat (13) @(negedge clk);
        btn_run = 1'b0;
        repeat (DB + 8) @(negedge clk);
        check("run_held_once", enable, 0);

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            p0 = plus_cnt;
            m0 = minus_cnt;
            hold_btn(vecs[i].btn, vecs[i].hold);
            check($sformatf("vec%0d_mode", i), mode, vecs[i].exp_mode);
            check($sformatf("vec%0d_enable", i), enable, vecs[i].exp_en);
            check($sformatf("vec%0d_plus", i), plus_cnt - p0, vecs[i].exp_dp);
            check($sformatf("vec%0d_minus", i), minus_cnt - m0, vecs[i].exp_dm);
        end

        // Simultaneous plus+minus press in mode 10 is discarded
        p0 = plus_cnt;
        m0 = minus_cnt;
        @(negedge clk);
        btn_plus = 1'b1;
        btn_minus = 1'b1;
        repeat (6) @(negedge clk);
        btn_plus = 1'b0;
        btn_minus = 1'b0;
        repeat (DB + 8) @(negedge clk);
        check("both_plus", plus_cnt - p0, 0);
        check("both_minus", minus_cnt - m0, 0);

        // Auto-repeat on held minus in mode 01
        hold_btn(0, 6);
        hold_btn(0, 6);
        hold_btn(0, 6);
        check("rpt_mode", mode, 1);
        minus_t.delete();
        p0 = plus_cnt;
        exp_off.push_back(0);
`ifdef TIME_CTRL_AUTO_REPEAT_EN
        for (int t = DB + 2 + RD; t <= 30 + DB + 1; t += RP) exp_off.push_back(t - (DB + 2));
`endif
        hold_btn(3, 30);
        check("rpt_count", minus_t.size(), exp_off.size());
        check("rpt_count_model", minus_t.size(), rpt_pulses(30));
        for (int i = 1; i < exp_off.size() && i < minus_t.size(); i++)
            check($sformatf("rpt_off%0d", i), minus_t[i] - minus_t[0], exp_off[i]);
        check("rpt_no_plus", plus_cnt - p0, 0);
        m0 = minus_cnt;
        repeat (20) @(negedge clk);
        check("rpt_after_release", minus_cnt - m0, 0);

        // Cancel by opposite key in mode 11
        hold_btn(0, 6);
        hold_btn(0, 6);
        check("opp_mode", mode, 3);
        p0 = plus_cnt;
        m0 = minus_cnt;
        @(negedge clk);
        btn_plus = 1'b1;
        repeat (5) @(negedge clk);
        btn_minus = 1'b1;
        repeat (25) @(negedge clk);
        btn_plus = 1'b0;
        btn_minus = 1'b0;
        repeat (DB + 8) @(negedge clk);
        check("opp_plus", plus_cnt - p0, 1);
        check("opp_minus", minus_cnt - m0, 0);

        // Cancel by mode change: start in 01, mode press moves to 10
        hold_btn(0, 6);
        hold_btn(0, 6);
        check("mchg_start_mode", mode, 1);
        p0 = plus_cnt;
        @(negedge clk);
        btn_plus = 1'b1;
        repeat (3) @(negedge clk);
        btn_mode = 1'b1;
        repeat (6) @(negedge clk);
        btn_mode = 1'b0;
        repeat (31) @(negedge clk);
        btn_plus = 1'b0;
        repeat (DB + 8) @(negedge clk);
        check("mchg_mode", mode, 2);
        check("mchg_plus", plus_cnt - p0, 1);

        // Long hold in mode 10
        p0 = plus_cnt;
        hold_btn(2, 50);
        check("long_plus", plus_cnt - p0, rpt_pulses(50));

        // Key held through reset release gives a fresh press after debouncing
        @(negedge clk);
        btn_minus = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst2_mode", mode, 0);
        check("rst2_enable", enable, 1);
        reset_n = 1'b1;
        repeat (DB + 6) @(negedge clk);
        btn_minus = 1'b0;
        hold_btn(0, 6);
        m0 = minus_cnt;
        hold_btn(3, 6);
        check("rst2_minus", minus_cnt - m0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
